// File: rtl/slt_sltu_cmp32_if.sv
`default_nettype none
// ============================================================================
//  Module      : slt_sltu_cmp32_if
//  Description : Operand/result bundle for the registered set-less-than
//                comparator.
//                master modport : drives operands, observes results
//                slave  modport : receives operands, drives results
//                Signals: I_VALID, I_OP_A[WIDTH], I_OP_B[WIDTH], I_U,
//                         O_VALID, O_Result, O_EQ (only with SLT_SLTU_FLAGS_EN)
//  Optional    : SLT_SLTU_FLAGS_EN adds the O_EQ result flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface slt_sltu_cmp32_if #(
   parameter int WIDTH = 32
);
   logic             I_VALID;
   logic [WIDTH-1:0] I_OP_A;
   logic [WIDTH-1:0] I_OP_B;
   logic             I_U;
   logic             O_VALID;
   logic             O_Result;
`ifdef SLT_SLTU_FLAGS_EN
   logic             O_EQ;
`endif

`ifdef SLT_SLTU_FLAGS_EN
   modport master (output I_VALID, I_OP_A, I_OP_B, I_U,
                   input  O_VALID, O_Result, O_EQ);
   modport slave  (input  I_VALID, I_OP_A, I_OP_B, I_U,
                   output O_VALID, O_Result, O_EQ);
`else
   modport master (output I_VALID, I_OP_A, I_OP_B, I_U,
                   input  O_VALID, O_Result);
   modport slave  (input  I_VALID, I_OP_A, I_OP_B, I_U,
                   output O_VALID, O_Result);
`endif
endinterface
`default_nettype wire

// File: rtl/slt_sltu_cmp32.sv
`default_nettype none
// ============================================================================
//  Module      : slt_sltu_cmp32 (+ full-adder cell slt_sltu_cmp32_fa)
//  Description : Registered 32-bit SLT/SLTU comparator for the RV32I ALU.
//                A - B is formed as A + ~B + 1 on a ripple chain of full
//                adders; the less-than flag comes from the carry (unsigned)
//                or N ^ V (signed), and is registered with 1-cycle latency.
//  Ports       : I_CLK    - rising-edge clock
//                I_RST_N  - synchronous reset, active-low
//                bus      - slave modport of slt_sltu_cmp32_if
//                           (I_VALID, I_OP_A, I_OP_B, I_U -> O_VALID, O_Result
//                            and O_EQ when enabled)
//  Optional    : SLT_SLTU_FLAGS_EN adds registered O_EQ (A == B)
//  Revision    : 1.0 - initial release
// ============================================================================

// Single-bit full adder cell used to build the ripple subtractor.
module slt_sltu_cmp32_fa (
   input  wire logic a,
   input  wire logic b,
   input  wire logic ci,
   output logic      s,
   output logic      co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module slt_sltu_cmp32 #(
   parameter int WIDTH = 32
) (
   input  wire logic        I_CLK,
   input  wire logic        I_RST_N,
   slt_sltu_cmp32_if.slave  bus
);

   logic [WIDTH-1:0] b_inv;
   logic [WIDTH-1:0] diff;
   logic [WIDTH:0]   carry;
   logic             neg;
   logic             ovf;
   logic             lt_signed;
   logic             lt_unsigned;
   logic             result_next;
   logic             result_reg;
   logic             valid_reg;

   assign b_inv    = ~bus.I_OP_B;
   // Carry-in of 1 completes the two's complement of B.
   assign carry[0] = 1'b1;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
         slt_sltu_cmp32_fa u_fa (
            .a  (bus.I_OP_A[i]),
            .b  (b_inv[i]),
            .ci (carry[i]),
            .s  (diff[i]),
            .co (carry[i+1])
         );
      end
   endgenerate

   // No borrow (carry-out = 1) means A >= B unsigned.
   assign lt_unsigned = ~carry[WIDTH];
   assign neg         = diff[WIDTH-1];
   // Overflow only when the operand signs differ and the difference sign
   // disagrees with A; N ^ V then still yields the true signed order.
   assign ovf         = (bus.I_OP_A[WIDTH-1] ^ bus.I_OP_B[WIDTH-1]) &
                        (bus.I_OP_A[WIDTH-1] ^ diff[WIDTH-1]);
   assign lt_signed   = neg ^ ovf;
   assign result_next = bus.I_U ? lt_unsigned : lt_signed;

   always_ff @(posedge I_CLK) begin
      if (!I_RST_N) begin
         result_reg <= 1'b0;
         valid_reg  <= 1'b0;
      end else if (bus.I_VALID) begin
         result_reg <= result_next;
         valid_reg  <= 1'b1;
      end else begin
         valid_reg  <= 1'b0;
      end
   end

   assign bus.O_Result = result_reg;
   assign bus.O_VALID  = valid_reg;

`ifdef SLT_SLTU_FLAGS_EN
   logic eq_reg;

   always_ff @(posedge I_CLK) begin
      if (!I_RST_N) begin
         eq_reg <= 1'b0;
      end else if (bus.I_VALID) begin
         eq_reg <= (diff == '0);
      end
   end

   assign bus.O_EQ = eq_reg;
`else
   // Only the sign bit of the difference feeds the compare flags here.
   logic [WIDTH-2:0] unused_diff_bits;
   assign unused_diff_bits = diff[WIDTH-2:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_slt_sltu_cmp32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slt_sltu_cmp32
//  Description : Directed self-checking bench for slt_sltu_cmp32: reset,
//                signed and unsigned vectors back-to-back, mode toggle,
//                hold while idle, reset over a valid request, and (with
//                SLT_SLTU_FLAGS_EN) the O_EQ flag plus random vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slt_sltu_cmp32;

   logic clk;
   logic rst_n;
   int   n_compared;
   int   n_mismatched;

   slt_sltu_cmp32_if #(.WIDTH(32)) bus ();

   slt_sltu_cmp32 #(.WIDTH(32)) dut (
      .I_CLK   (clk),
      .I_RST_N (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic observed, input logic expected);
      n_compared++;
      assert (observed === expected)
      else begin
         n_mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // One valid compare; result is checked just after the capturing edge.
   task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic u, input logic exp_lt);
      @(negedge clk);
      bus.I_VALID = 1'b1;
      bus.I_OP_A  = a;
      bus.I_OP_B  = b;
      bus.I_U     = u;
      @(posedge clk);
      #1;
      check({tag, "_valid"}, bus.O_VALID, 1'b1);
      check(tag, bus.O_Result, exp_lt);
`ifdef SLT_SLTU_FLAGS_EN
      check({tag, "_eq"}, bus.O_EQ, (a == b));
`endif
   endtask

   task automatic idle(input string tag, input logic exp_hold);
      @(negedge clk);
      bus.I_VALID = 1'b0;
      bus.I_OP_A  = $urandom;
      bus.I_OP_B  = $urandom;
      bus.I_U     = 1'($urandom);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, bus.O_VALID, 1'b0);
      check(tag, bus.O_Result, exp_hold);
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;

      // Reset held for two edges while a request is offered.
      rst_n       = 1'b0;
      bus.I_VALID = 1'b1;
      bus.I_OP_A  = 32'd5;
      bus.I_OP_B  = 32'd10;
      bus.I_U     = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check("rst_valid", bus.O_VALID, 1'b0);
         check("rst_result", bus.O_Result, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Signed, back-to-back.
      apply("s_5_10",     32'd5,          32'd10,         1'b0, 1'b1);
      apply("s_m5_5",     32'hFFFF_FFFB,  32'd5,          1'b0, 1'b1);
      apply("s_5_m5",     32'd5,          32'hFFFF_FFFB,  1'b0, 1'b0);
      apply("s_m10_m5",   32'hFFFF_FFF6,  32'hFFFF_FFFB,  1'b0, 1'b1);
      apply("s_5_5",      32'd5,          32'd5,          1'b0, 1'b0);
      apply("s_0_0",      32'd0,          32'd0,          1'b0, 1'b0);
      apply("s_max_min",  32'h7FFF_FFFF,  32'h8000_0000,  1'b0, 1'b0);
      apply("s_min_max",  32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 1'b1);
      apply("s_ff_ff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0);

      // Unsigned, back-to-back.
      apply("u_5_10",     32'd5,          32'd10,         1'b1, 1'b1);
      apply("u_ff_1",     32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0);
      apply("u_100_100",  32'd100,        32'd100,        1'b1, 1'b0);
      apply("u_0_1",      32'd0,          32'd1,          1'b1, 1'b1);
      apply("u_ff_fe",    32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1, 1'b0);
      apply("u_0_ff",     32'd0,          32'hFFFF_FFFF,  1'b1, 1'b1);
      apply("u_ff_ff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0);
      apply("u_min_max",  32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 1'b0);

      // Mode toggle on identical operands, no bubble.
      apply("tog_signed",   32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      apply("tog_unsigned", 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
      apply("tog_back",     32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);

      // Hold while idle.
      apply("hold_pre", 32'd5, 32'd10, 1'b0, 1'b1);
      idle("hold_1", 1'b1);
      idle("hold_2", 1'b1);
      idle("hold_3", 1'b1);

      // A zero result must also be held.
      apply("hold0_pre", 32'd10, 32'd5, 1'b0, 1'b0);
      idle("hold0_1", 1'b0);

`ifdef SLT_SLTU_FLAGS_EN
      apply("eq_same", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
      apply("eq_1_2",  32'd1,         32'd2,         1'b1, 1'b1);
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        exp_lt;
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : 32'($urandom);
            exp_lt = (m == 1) ? (ra < rb) : ($signed(ra) < $signed(rb));
            apply("rand", ra, rb, 1'(m), exp_lt);
         end
      end
`endif

      // Leave a 1 in the register, then reset over a valid request.
      apply("rstv_pre", 32'd5, 32'd10, 1'b0, 1'b1);
      @(negedge clk);
      rst_n       = 1'b0;
      bus.I_VALID = 1'b1;
      bus.I_OP_A  = 32'd5;
      bus.I_OP_B  = 32'd10;
      bus.I_U     = 1'b1;
      @(posedge clk);
      #1;
      check("rstv_valid", bus.O_VALID, 1'b0);
      check("rstv_result", bus.O_Result, 1'b0);
`ifdef SLT_SLTU_FLAGS_EN
      check("rstv_eq", bus.O_EQ, 1'b0);
`endif
      @(negedge clk);
      rst_n       = 1'b1;
      bus.I_VALID = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_valid", bus.O_VALID, 1'b0);
      check("post_rst_result", bus.O_Result, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire
